motion_cmd_proc: RTL and testbench
==================================

MOTION_CMD_PROC -- requirements
Module: motion_cmd_proc

Interface
REQ-001 Parameters (name, default, meaning):
- FAST_SIM, 1, ramp steps scaled x8 for simulation.
- HEAD_W, 12, heading/error width, >=9.
- FRWRD_W, 10, forward speed width.
- RAMP_UP, 4, speed increment per heading_rdy.
- RAMP_DN, 8, speed decrement per heading_rdy.
- NUDGE, 95, IR nudge magnitude.
- HEAD_TOL, 48, alignment window half-width.
- TMO, 64, heading_rdy pulses allowed between line crossings.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- cmd, in, 16, command word.
- cmd_rdy, in, 1, command valid.
- clr_cmd_rdy, out, 1, command consumed pulse.
- send_resp, out, 1, response strobe.
- resp, out, 8, response code.
- strt_cal, out, 1, gyro calibration start pulse.
- cal_done, in, 1, calibration complete.
- heading, in, HEAD_W signed, gyro heading.
- heading_rdy, in, 1, heading valid pulse.
- lftIR, in, 1, left nudge sensor.
- cntrIR, in, 1, line sensor.
- rghtIR, in, 1, right nudge sensor.
- error, out, HEAD_W signed, PID error.
- frwrd, out, FRWRD_W, forward speed.
- moving, out, 1, motion active.
- tour_go, out, 1, tour start pulse.
- fanfare_go, out, 1, fanfare pulse.

Function
REQ-003 Opcodes are cmd[15:12]: 0000 CAL; 001f MOVE, where f=cmd[12] requests fanfare; 0100 TOUR; 0101 STOP; any other value is ILLEGAL.
REQ-004 The FSM has states IDLE, CAL, ALIGN, RUP, RDOWN.
REQ-005 In IDLE with cmd_rdy, the block asserts clr_cmd_rdy for 1 cycle, then:
- CAL: pulse strt_cal, go to CAL.
- MOVE: latch cmd, go to ALIGN.
- TOUR: pulse tour_go, stay in IDLE.
- STOP: send_resp with resp=0xA5.
- ILLEGAL: send_resp with resp=0xEE.
REQ-006 In CAL, cal_done causes send_resp with resp=0xA5 and a return to IDLE.
REQ-007 Desired heading is 0 when latched cmd[11:4]==0, else {cmd[11:4], all-ones low bits}. Error = heading - desired + nudge, computed modulo 2^HEAD_W.
REQ-008 Nudge is +NUDGE if lftIR, else -NUDGE if rghtIR, else 0; lftIR wins when both are set.
REQ-009 In ALIGN and RUP, frwrd ramps up. ALIGN goes to RUP when -HEAD_TOL < error < HEAD_TOL, signed compare.
REQ-010 frwrd changes only on cycles with heading_rdy:
- Ramp up: +RAMP_UP (x8 if FAST_SIM), saturating at all-ones.
- Ramp down: -RAMP_DN (x8 if FAST_SIM), saturating at 0; no wrap in either direction.
REQ-011 A cntrIR rising edge, registered 1 cycle, increments the line count. The count clears on MOVE acceptance.
REQ-012 In RUP, when line count == 2*cmd[3:0], the block pulses fanfare_go if f=1 and goes to RDOWN with resp code 0xA5 pending.
REQ-013 A MOVE with cmd[3:0]==0 completes immediately on entering RUP.
REQ-014 Timeout counter:
- Counts heading_rdy pulses in ALIGN/RUP.
- Clears on every cntrIR rising edge and on MOVE acceptance.
- Reaching TMO forces RDOWN with code 0x7E pending.
REQ-015 STOP with cmd_rdy in ALIGN or RUP is consumed (clr_cmd_rdy) and forces RDOWN with code 0x5C pending. Any other command while busy is not consumed.
REQ-016 In RDOWN, when frwrd==0, the block pulses send_resp with the pending code and returns to IDLE.
REQ-017 moving=1 in ALIGN, RUP and RDOWN; 0 otherwise.
REQ-018 All pulse outputs (clr_cmd_rdy, send_resp, strt_cal, tour_go, fanfare_go) are exactly 1 cycle wide.
REQ-019 resp holds its last value between responses.
REQ-020 Simultaneous timeout and move completion in the same cycle: completion wins (0xA5).

Reset
REQ-021 On rst_n low:
- state=IDLE.
- frwrd=0, resp=0x00.
- line count, timeout counter and latched cmd = 0.
- cntrIR history register = 1, so no false edge is seen after reset.
- All pulse outputs = 0.
REQ-022 Reset mid-move stops immediately: frwrd=0 with no ramp down and no response.

Structure
REQ-023 Package motion_pkg holds:
- state_t enum.
- Opcode constants.
- Response constants: ACK 0xA5, NACK 0xEE, TMO 0x7E, ABORT 0x5C.
REQ-024 Submodule frwrd_ramp implements the saturating ramp counter (REQ-010), parameterised by FRWRD_W, step sizes and FAST_SIM.

Verification
REQ-025 CAL command 0x0000, cal_done after 10 cycles -> strt_cal pulse, then send_resp with resp=0xA5.
REQ-026 MOVE 0x2002, heading aligned, 4 cntrIR pulses, FAST_SIM=1 -> frwrd ramps in steps of 32 to saturation, RDOWN after the 4th edge, resp=0xA5 when frwrd reaches 0.
REQ-027 MOVE 0x3001 -> fanfare_go pulses once at the 2nd line edge.
REQ-028 MOVE 0x2003 with no cntrIR, TMO=64 -> RDOWN after 64 heading_rdy pulses, resp=0x7E.
REQ-029 STOP 0x5000 issued during RUP -> clr_cmd_rdy, ramp down, resp=0x5C; a MOVE issued during RUP stays unconsumed.
REQ-030 Command 0xF000 in IDLE -> resp=0xEE, frwrd stays 0.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types and constants for the motion command processor.
package motion_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAL,
        ALIGN,
        RUP,
        RDOWN
    } state_t;

    localparam logic [3:0] OP_CAL  = 4'b0000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [3:0] OP_TOUR = 4'b0100;
    localparam logic [3:0] OP_STOP = 4'b0101;

    localparam logic [7:0] RESP_ACK   = 8'hA5;
    localparam logic [7:0] RESP_NACK  = 8'hEE;
    localparam logic [7:0] RESP_TMO   = 8'h7E;
    localparam logic [7:0] RESP_ABORT = 8'h5C;

    // Bit 0 of a MOVE opcode is the fanfare request, so two opcodes decode as MOVE.
    function automatic logic is_move(input logic [3:0] op);
        return op[3:1] == OP_MOVE;
    endfunction

endpackage

// File: rtl/frwrd_ramp.sv
// Saturating forward-speed ramp; moves one step per enabled cycle.
module frwrd_ramp #(
    parameter int FRWRD_W  = 10,
    parameter int RAMP_UP  = 4,
    parameter int RAMP_DN  = 8,
    parameter int FAST_SIM = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step_en,
    input  logic               up,
    input  logic               dn,
    output logic [FRWRD_W-1:0] frwrd
);

    localparam int SCALE = (FAST_SIM != 0) ? 8 : 1;
    localparam logic [FRWRD_W:0] UP_STEP = (FRWRD_W+1)'(RAMP_UP * SCALE);
    localparam logic [FRWRD_W:0] DN_STEP = (FRWRD_W+1)'(RAMP_DN * SCALE);

    logic [FRWRD_W:0] sum;

    always_comb begin
        sum = {1'b0, frwrd} + UP_STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frwrd <= '0;
        end else if (step_en) begin
            if (up) begin
                frwrd <= sum[FRWRD_W] ? '1 : sum[FRWRD_W-1:0];
            end else if (dn) begin
                if ({1'b0, frwrd} < DN_STEP)
                    frwrd <= '0;
                else
                    frwrd <= frwrd - DN_STEP[FRWRD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/motion_cmd_proc.sv
// Motion command processor: decodes host commands, steers heading and ramps
// forward speed between line crossings, and reports completion codes.
module motion_cmd_proc
    import motion_pkg::*;
#(
    parameter int FAST_SIM = 1,
    parameter int HEAD_W   = 12,
    parameter int FRWRD_W  = 10,
    parameter int RAMP_UP  = 4,
    parameter int RAMP_DN  = 8,
    parameter int NUDGE    = 95,
    parameter int HEAD_TOL = 48,
    parameter int TMO      = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              cmd,
    input  logic                     cmd_rdy,
    output logic                     clr_cmd_rdy,
    output logic                     send_resp,
    output logic [7:0]               resp,
    output logic                     strt_cal,
    input  logic                     cal_done,
    input  logic signed [HEAD_W-1:0] heading,
    input  logic                     heading_rdy,
    input  logic                     lftIR,
    input  logic                     cntrIR,
    input  logic                     rghtIR,
    output logic signed [HEAD_W-1:0] error,
    output logic [FRWRD_W-1:0]       frwrd,
    output logic                     moving,
    output logic                     tour_go,
    output logic                     fanfare_go
);

    localparam int TMO_W = $clog2(TMO + 1);
    localparam logic signed [HEAD_W-1:0] TOL = HEAD_W'(HEAD_TOL);

    state_t                     state;
    logic [12:0]                cmd_l;
    logic [7:0]                 pend;
    logic                       cntr_prev;
    logic                       line_edge;
    logic [4:0]                 line_cnt;
    logic [TMO_W-1:0]           tmo_cnt;
    logic signed [HEAD_W-1:0]   desired;
    logic signed [HEAD_W-1:0]   nudge;
    logic [3:0]                 op;
    logic                       cmd_take;
    logic                       move_acc;
    logic                       driving;
    logic                       aligned;
    logic                       move_done;
    logic                       tmo_hit;

    always_comb begin
        desired = '0;
        if (cmd_l[11:4] != '0)
            desired = {cmd_l[11:4], {(HEAD_W-8){1'b1}}};
        nudge = '0;
        if (lftIR)
            nudge = HEAD_W'(NUDGE);
        else if (rghtIR)
            nudge = HEAD_W'(-NUDGE);
    end

    assign error = heading - desired + nudge;

    // clr_cmd_rdy is registered, so cmd_rdy is still high the cycle after a
    // consume; masking with it prevents taking the same command twice.
    assign op        = cmd[15:12];
    assign cmd_take  = cmd_rdy && !clr_cmd_rdy;
    assign move_acc  = (state == IDLE) && cmd_take && is_move(op);
    assign driving   = (state == ALIGN) || (state == RUP);
    assign aligned   = (error > -TOL) && (error < TOL);
    assign move_done = (line_cnt == {cmd_l[3:0], 1'b0});
    assign tmo_hit   = (tmo_cnt == TMO_W'(TMO));
    assign moving    = driving || (state == RDOWN);

    frwrd_ramp #(
        .FRWRD_W (FRWRD_W),
        .RAMP_UP (RAMP_UP),
        .RAMP_DN (RAMP_DN),
        .FAST_SIM(FAST_SIM)
    ) u_ramp (
        .clk    (clk),
        .rst_n  (rst_n),
        .step_en(heading_rdy),
        .up     (driving),
        .dn     (state == RDOWN),
        .frwrd  (frwrd)
    );

    // History resets high so a line sensor already asserted at reset release
    // is not counted as a crossing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntr_prev <= 1'b1;
            line_edge <= 1'b0;
            line_cnt  <= '0;
            tmo_cnt   <= '0;
        end else begin
            cntr_prev <= cntrIR;
            line_edge <= cntrIR && !cntr_prev;
            if (move_acc)
                line_cnt <= '0;
            else if (line_edge)
                line_cnt <= line_cnt + 5'd1;
            if (move_acc || line_edge)
                tmo_cnt <= '0;
            else if (heading_rdy && driving)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_l       <= '0;
            pend        <= '0;
            resp        <= '0;
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            strt_cal    <= 1'b0;
            tour_go     <= 1'b0;
            fanfare_go  <= 1'b0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            strt_cal    <= 1'b0;
            tour_go     <= 1'b0;
            fanfare_go  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_take) begin
                        clr_cmd_rdy <= 1'b1;
                        if (op == OP_CAL) begin
                            strt_cal <= 1'b1;
                            state    <= CAL;
                        end else if (is_move(op)) begin
                            cmd_l <= cmd[12:0];
                            state <= ALIGN;
                        end else if (op == OP_TOUR) begin
                            tour_go <= 1'b1;
                        end else begin
                            send_resp <= 1'b1;
                            resp      <= (op == OP_STOP) ? RESP_ACK : RESP_NACK;
                        end
                    end
                end
                CAL: begin
                    if (cal_done) begin
                        send_resp <= 1'b1;
                        resp      <= RESP_ACK;
                        state     <= IDLE;
                    end
                end
                ALIGN, RUP: begin
                    // Completion is tested before timeout so a simultaneous
                    // hit reports success.
                    if (cmd_take && op == OP_STOP) begin
                        clr_cmd_rdy <= 1'b1;
                        pend        <= RESP_ABORT;
                        state       <= RDOWN;
                    end else if (state == RUP && move_done) begin
                        fanfare_go <= cmd_l[12];
                        pend       <= RESP_ACK;
                        state      <= RDOWN;
                    end else if (tmo_hit) begin
                        pend  <= RESP_TMO;
                        state <= RDOWN;
                    end else if (state == ALIGN && aligned) begin
                        state <= RUP;
                    end
                end
                RDOWN: begin
                    if (frwrd == '0) begin
                        send_resp <= 1'b1;
                        resp      <= pend;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_cmd_proc.sv
// Self-checking bench for motion_cmd_proc against a transaction-level model.
`timescale 1ns/1ps
module tb_motion_cmd_proc;

    localparam int HEAD_W   = 12;
    localparam int FRWRD_W  = 10;
    localparam int TMO      = 64;
    localparam int NUDGE    = 95;
    localparam int HEAD_TOL = 48;
    localparam int UP_STEP  = 4 * 8;
    localparam int DN_STEP  = 8 * 8;
    localparam int FMAX     = (1 << FRWRD_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic cmd_rdy = 1'b0, cal_done = 1'b0, heading_rdy = 1'b0;
    logic lftIR = 1'b0, cntrIR = 1'b0, rghtIR = 1'b0;
    logic signed [HEAD_W-1:0] heading = '0;
    logic clr_cmd_rdy, send_resp, strt_cal, moving, tour_go, fanfare_go;
    logic [7:0] resp;
    logic signed [HEAD_W-1:0] error;
    logic [FRWRD_W-1:0] frwrd;

    int n_cmp = 0, n_err = 0;
    int resp_cnt = 0, clr_cnt = 0, cal_cnt = 0, tour_cnt = 0, fan_cnt = 0;
    logic [7:0] last_resp = '0;
    int hr_since_acc = 0, dn_hr = 0;
    bit dn_seen = 0;
    bit hr_en = 0;
    int hr_per = 3;
    logic hr_prev = 1'b0;
    logic [FRWRD_W-1:0] frwrd_prev = '0;
    logic [4:0] pulses_prev = '0;

    motion_cmd_proc #(
        .FAST_SIM(1), .HEAD_W(HEAD_W), .FRWRD_W(FRWRD_W), .RAMP_UP(4),
        .RAMP_DN(8), .NUDGE(NUDGE), .HEAD_TOL(HEAD_TOL), .TMO(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
        .strt_cal(strt_cal), .cal_done(cal_done), .heading(heading),
        .heading_rdy(heading_rdy), .lftIR(lftIR), .cntrIR(cntrIR),
        .rghtIR(rghtIR), .error(error), .frwrd(frwrd), .moving(moving),
        .tour_go(tour_go), .fanfare_go(fanfare_go)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ramp_up_ref(input int p);
        return (p + UP_STEP > FMAX) ? FMAX : p + UP_STEP;
    endfunction

    function automatic int ramp_dn_ref(input int p);
        return (p - DN_STEP < 0) ? 0 : p - DN_STEP;
    endfunction

    function automatic int desired_ref(input int b);
        return (b == 0) ? 0 : b * (1 << (HEAD_W - 8)) + (1 << (HEAD_W - 8)) - 1;
    endfunction

    function automatic logic [HEAD_W-1:0] exp_err(input int hd, input int b, input bit l, input bit r);
        int v;
        v = hd - desired_ref(b) + (l ? NUDGE : (r ? -NUDGE : 0));
        return v[HEAD_W-1:0];
    endfunction

    function automatic logic [7:0] predict_resp(input bit stopped, input int crossings, input int n);
        if (stopped) return 8'h5C;
        if (crossings >= 2 * n) return 8'hA5;
        return 8'h7E;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_cmd(input logic [15:0] c, input string tag);
        bit got;
        got = 0;
        cmd = c;
        cmd_rdy = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            step(1);
            got = clr_cmd_rdy;
        end
        cmd_rdy = 1'b0;
        chk({tag, "_accept"}, 32'(got), 32'd1);
    endtask

    task automatic expect_resp(input string tag, input int base, input logic [7:0] exp, input int budget);
        for (int k = 0; k < budget && resp_cnt == base; k++) step(1);
        step(1);
        chk({tag, "_resp_cnt"}, 32'(resp_cnt - base), 32'd1);
        chk({tag, "_resp"}, {24'd0, last_resp}, {24'd0, exp});
        chk({tag, "_resp_hold"}, {24'd0, resp}, {24'd0, exp});
    endtask

    task automatic cross_line();
        cntrIR = 1'b1;
        step(2);
        cntrIR = 1'b0;
        step(8);
    endtask

    // heading_rdy generator
    initial begin
        int ctr;
        ctr = 0;
        forever begin
            @(posedge clk);
            #2;
            ctr++;
            heading_rdy = hr_en && (ctr % hr_per == 0);
        end
    end

    // Output monitor: ramp steps, pulse widths, pulse counts
    initial begin
        logic [4:0] cur;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (clr_cmd_rdy) hr_since_acc = 0;
                else hr_since_acc += int'(hr_prev);
                if (frwrd != frwrd_prev) begin
                    chk("frwrd_on_hr", {31'd0, hr_prev}, 32'd1);
                    if (frwrd > frwrd_prev) begin
                        chk("frwrd_up", 32'(frwrd), 32'(ramp_up_ref(int'(frwrd_prev))));
                    end else begin
                        chk("frwrd_dn", 32'(frwrd), 32'(ramp_dn_ref(int'(frwrd_prev))));
                        if (!dn_seen) begin
                            dn_seen = 1;
                            dn_hr = hr_since_acc;
                        end
                    end
                end
                cur = {clr_cmd_rdy, send_resp, strt_cal, tour_go, fanfare_go};
                if ((cur & pulses_prev) != '0)
                    chk("pulse_width", 32'(cur & pulses_prev), 32'd0);
                if (clr_cmd_rdy) clr_cnt++;
                if (strt_cal) cal_cnt++;
                if (tour_go) tour_cnt++;
                if (fanfare_go) fan_cnt++;
                if (send_resp) begin
                    resp_cnt++;
                    last_resp = resp;
                end
                pulses_prev = cur;
            end else begin
                pulses_prev = '0;
            end
            frwrd_prev = frwrd;
            hr_prev = heading_rdy;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, fb, cb, b, n, crossings;
        bit f, full;
        logic [3:0] opr;
        logic [15:0] c;

        // Reset state
        step(3);
        chk("rst_frwrd", 32'(frwrd), 32'd0);
        chk("rst_resp", {24'd0, resp}, 32'd0);
        chk("rst_moving", {31'd0, moving}, 32'd0);
        chk("rst_pulses", {27'd0, clr_cmd_rdy, send_resp, strt_cal, tour_go, fanfare_go}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // Calibration
        base = resp_cnt;
        cb = cal_cnt;
        send_cmd(16'h0000, "cal");
        step(2);
        chk("cal_strt", 32'(cal_cnt - cb), 32'd1);
        step(8);
        chk("cal_wait", 32'(resp_cnt - base), 32'd0);
        cal_done = 1'b1;
        step(1);
        cal_done = 1'b0;
        expect_resp("cal", base, 8'hA5, 20);

        // Tour
        base = resp_cnt;
        cb = tour_cnt;
        send_cmd(16'h4000, "tour");
        step(3);
        chk("tour_go", 32'(tour_cnt - cb), 32'd1);
        chk("tour_noresp", 32'(resp_cnt - base), 32'd0);

        // Stop while idle
        base = resp_cnt;
        send_cmd(16'h5000, "stop_idle");
        expect_resp("stop_idle", base, 8'hA5, 20);

        // Illegal opcodes
        for (int i = 0; i < 4; i++) begin
            opr = (i == 0) ? 4'hF : 4'($urandom_range(6, 15));
            c = {opr, 12'($urandom)};
            base = resp_cnt;
            send_cmd(c, "illegal");
            expect_resp("illegal", base, 8'hEE, 20);
            chk("illegal_frwrd", 32'(frwrd), 32'd0);
        end

        // Alignment window edges (no heading_rdy, so speed stays 0)
        hr_en = 0;
        heading = 12'sd48;
        base = resp_cnt;
        send_cmd(16'h2000, "align");
        step(10);
        chk("align_p48_hold", 32'(resp_cnt - base), 32'd0);
        chk("align_moving", {31'd0, moving}, 32'd1);
        heading = -12'sd48;
        step(10);
        chk("align_m48_hold", 32'(resp_cnt - base), 32'd0);
        heading = 12'sd47;
        expect_resp("align_p47", base, 8'hA5, 20);
        heading = -12'sd48;
        lftIR = 1'b1;
        base = resp_cnt;
        send_cmd(16'h2000, "align_nudge");
        expect_resp("align_nudge", base, 8'hA5, 20);
        lftIR = 1'b0;

        // Heading error with random headings and IR sensors
        b = $urandom_range(1, 255);
        send_cmd({4'b0010, 8'(b), 4'hF}, "err");
        for (int i = 0; i < 24; i++) begin
            heading = HEAD_W'($urandom);
            lftIR = 1'($urandom);
            rghtIR = 1'($urandom);
            #1;
            chk("error", {20'd0, error}, {20'd0, exp_err(int'(heading), b, lftIR, rghtIR)});
            step(1);
        end
        lftIR = 1'b0;
        rghtIR = 1'b0;
        base = resp_cnt;
        send_cmd(16'h5000, "err_stop");
        expect_resp("err_stop", base, 8'hA5 ^ 8'hF9, 20);

        // Full move with saturation and 4 line crossings
        heading = '0;
        hr_per = 3;
        hr_en = 1;
        dn_seen = 0;
        fb = fan_cnt;
        base = resp_cnt;
        send_cmd(16'h2002, "move2");
        step(110);
        chk("move2_sat", 32'(frwrd), 32'(FMAX));
        for (int i = 0; i < 3; i++) cross_line();
        chk("move2_no_dn_early", 32'(dn_seen), 32'd0);
        cross_line();
        expect_resp("move2", base, predict_resp(0, 4, 2), 400);
        chk("move2_ramped_dn", 32'(dn_seen), 32'd1);
        chk("move2_frwrd0", 32'(frwrd), 32'd0);
        chk("move2_moving", {31'd0, moving}, 32'd0);
        chk("move2_nofan", 32'(fan_cnt - fb), 32'd0);

        // Fanfare at second crossing
        fb = fan_cnt;
        base = resp_cnt;
        send_cmd(16'h3001, "fan");
        step(20);
        cross_line();
        chk("fan_after1", 32'(fan_cnt - fb), 32'd0);
        cross_line();
        expect_resp("fan", base, predict_resp(0, 2, 1), 400);
        chk("fan_once", 32'(fan_cnt - fb), 32'd1);

        // Timeout with no line crossings
        hr_per = $urandom_range(2, 4);
        dn_seen = 0;
        base = resp_cnt;
        send_cmd(16'h2003, "tmo");
        expect_resp("tmo", base, predict_resp(0, 0, 3), 800);
        chk("tmo_hr_to_first_dn", 32'(dn_hr), 32'(TMO + 1));

        // STOP during ramp-up; a MOVE while busy is left pending
        hr_per = 3;
        dn_seen = 0;
        base = resp_cnt;
        send_cmd(16'h2005, "abort");
        step(40);
        cb = clr_cnt;
        cmd = 16'h2001;
        cmd_rdy = 1'b1;
        step(15);
        chk("busy_move_unconsumed", 32'(clr_cnt - cb), 32'd0);
        send_cmd(16'h5000, "abort_stop");
        expect_resp("abort", base, predict_resp(1, 0, 5), 400);
        chk("abort_ramped_dn", 32'(dn_seen), 32'd1);

        // Randomized moves against the transaction model
        for (int i = 0; i < 4; i++) begin
            b = $urandom_range(0, 255);
            n = $urandom_range(1, 3);
            f = 1'($urandom);
            full = 1'($urandom);
            crossings = full ? 2 * n : $urandom_range(0, 2 * n - 1);
            heading = HEAD_W'(desired_ref(b));
            hr_per = $urandom_range(2, 4);
            fb = fan_cnt;
            base = resp_cnt;
            send_cmd({3'b001, f, 8'(b), 4'(n)}, "rnd");
            step(10);
            for (int k = 0; k < crossings; k++) cross_line();
            expect_resp("rnd", base, predict_resp(0, crossings, n), 900);
            chk("rnd_fan", 32'(fan_cnt - fb), 32'(f && crossings >= 2 * n));
        end

        // Reset mid-move
        heading = '0;
        hr_per = 3;
        send_cmd(16'h2005, "rstmove");
        step(30);
        chk("rstmove_running", 32'(frwrd != '0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmove_frwrd", 32'(frwrd), 32'd0);
        chk("rstmove_moving", {31'd0, moving}, 32'd0);
        step(3);
        rst_n = 1'b1;
        base = resp_cnt;
        step(40);
        chk("rstmove_noresp", 32'(resp_cnt - base), 32'd0);
        chk("rstmove_frwrd_after", 32'(frwrd), 32'd0);
        chk("rstmove_resp", {24'd0, resp}, 32'd0);
        hr_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
